// File: rtl/param_register_file.sv
// Parametrised register file: two prioritised write ports, two combinational read ports,
// optional write-to-read bypass, optional hardwired-zero R0 and a per-register busy scoreboard.
module param_register_file #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                   In_clock,
    input  logic                   In_reset,
    input  logic [ADDR_W-1:0]      In_RF_Read_addr1,
    input  logic [ADDR_W-1:0]      In_RF_Read_addr2,
    output logic [DATA_W-1:0]      Out_RF_Read_data1,
    output logic [DATA_W-1:0]      Out_RF_Read_data2,
    output logic                   Out_RF_Read_busy1,
    output logic                   Out_RF_Read_busy2,
    input  logic [ADDR_W-1:0]      In_RF_Write_addr1,
    input  logic [DATA_W-1:0]      In_RF_Write_data1,
    input  logic                   In_RF_Write_en_1,
    input  logic [ADDR_W-1:0]      In_RF_Write_addr2,
    input  logic [DATA_W-1:0]      In_RF_Write_data2,
    input  logic                   In_RF_Write_en_2,
    input  logic [ADDR_W-1:0]      In_RF_Reserve_addr,
    input  logic                   In_RF_Reserve_en,
    output logic [(2**ADDR_W)-1:0] Out_RF_Busy_vec
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs    [DEPTH];
    logic [DATA_W-1:0] wr_data [DEPTH];
    logic [DEPTH-1:0]  wr_en;
    logic [DEPTH-1:0]  hit1;
    logic [DEPTH-1:0]  hit2;
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    // Port 1 beats port 2 on an address clash; a reservation beats a retiring write.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            hit1[i]    = In_RF_Write_en_1 && (In_RF_Write_addr1 == i[ADDR_W-1:0]);
            hit2[i]    = In_RF_Write_en_2 && (In_RF_Write_addr2 == i[ADDR_W-1:0]);
            wr_en[i]   = hit1[i] || hit2[i];
            wr_data[i] = hit1[i] ? In_RF_Write_data1 : In_RF_Write_data2;
            busy_d[i]  = busy_q[i];
            if (In_RF_Reserve_en && (In_RF_Reserve_addr == i[ADDR_W-1:0])) begin
                busy_d[i] = 1'b1;
            end else if (wr_en[i]) begin
                busy_d[i] = 1'b0;
            end
            if ((ZERO_REG != 0) && (i == 0)) begin
                wr_en[i]  = 1'b0;
                busy_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge In_clock or negedge In_reset) begin
        if (!In_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    regs[i] <= wr_data[i];
                end
            end
            busy_q <= busy_d;
        end
    end

    function automatic logic [DATA_W-1:0] read_mux(input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] stored);
        logic [DATA_W-1:0] val;
        val = stored;
        if (BYPASS != 0) begin
            if (In_RF_Write_en_1 && (In_RF_Write_addr1 == addr)) begin
                val = In_RF_Write_data1;
            end else if (In_RF_Write_en_2 && (In_RF_Write_addr2 == addr)) begin
                val = In_RF_Write_data2;
            end
        end
        if ((ZERO_REG != 0) && (addr == '0)) begin
            val = '0;
        end
        return val;
    endfunction

    // Busy is the registered bit only; a write in flight does not clear it early.
    always_comb begin
        Out_RF_Read_data1 = read_mux(In_RF_Read_addr1, regs[In_RF_Read_addr1]);
        Out_RF_Read_data2 = read_mux(In_RF_Read_addr2, regs[In_RF_Read_addr2]);
        Out_RF_Read_busy1 = busy_q[In_RF_Read_addr1];
        Out_RF_Read_busy2 = busy_q[In_RF_Read_addr2];
        Out_RF_Busy_vec   = busy_q;
    end

endmodule
